// File: rtl/ddr_timer_pkg.sv
// Shared types and constants for the DDR wait timer and the controller that loads it.
package ddr_timer_pkg;

  localparam int unsigned WIDTH_C = 8;

  // Wait lengths in controller clock cycles; TREFI_C is the refresh interval.
  localparam int unsigned TRCD_C  = 3;
  localparam int unsigned TRP_C   = 3;
  localparam int unsigned TRFC_C  = 60;
  localparam int unsigned TREFI_C = 195;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ddr_wait_timer_if.sv
// Request/status bundle between the DDR controller FSM (master) and the wait timer (slave).
interface ddr_wait_timer_if
  import ddr_timer_pkg::*;
#(
  parameter int unsigned WIDTH_P = WIDTH_C
);

  logic               load_i;
  logic [WIDTH_P-1:0] load_val_i;
  logic               reload_i;
  logic               en_i;
  logic               abort_i;
  logic [WIDTH_P-1:0] count_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output load_i, load_val_i, reload_i, en_i, abort_i,
    input  count_o, busy_o, done_o
  );

  modport slave (
    input  load_i, load_val_i, reload_i, en_i, abort_i,
    output count_o, busy_o, done_o
  );

endinterface

// File: rtl/counter_down.sv
// Loadable down-counter datapath: clear > load > decrement, with a count==1 flag.
module counter_down
  import ddr_timer_pkg::*;
#(
  parameter int unsigned WIDTH_P = WIDTH_C
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] load_val_i,
  input  logic               dec_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               is_one_c
);

  logic [WIDTH_P-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      // The zero guard keeps the counter from wrapping even if dec_i misfires.
      count_d = count_q - WIDTH_P'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_c = (count_q == WIDTH_P'(1));

endmodule

// File: rtl/ddr_wait_timer.sv
// DDR wait timer: one-shot or auto-reload countdown with a registered expiry pulse.
module ddr_wait_timer
  import ddr_timer_pkg::*;
#(
  parameter int unsigned WIDTH_P = WIDTH_C
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  ddr_wait_timer_if.slave  tmr
);

  state_e             state_d, state_q;
  logic [WIDTH_P-1:0] period_d, period_q;
  logic               reload_d, reload_q;
  logic               done_d, done_q;
  logic               busy_d, busy_q;

  logic               cnt_clear, cnt_load, cnt_dec;
  logic [WIDTH_P-1:0] cnt_load_val;
  logic [WIDTH_P-1:0] cnt_count;
  logic               cnt_is_one;

  counter_down #(
    .WIDTH_P (WIDTH_P)
  ) u_counter_down (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (cnt_clear),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt_count),
    .is_one_c   (cnt_is_one)
  );

  // Next state and counter controls; priority is abort > load > tick.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    reload_d     = reload_q;
    done_d       = 1'b0;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = tmr.load_val_i;

    unique case (state_q)
      IDLE: begin
        if (tmr.load_i) begin
          if (tmr.load_val_i != '0) begin
            cnt_load = 1'b1;
            period_d = tmr.load_val_i;
            reload_d = tmr.reload_i;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (tmr.abort_i) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (tmr.load_i) begin
          if (tmr.load_val_i != '0) begin
            cnt_load = 1'b1;
            period_d = tmr.load_val_i;
            reload_d = tmr.reload_i;
          end else begin
            cnt_clear = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end else if (tmr.en_i) begin
          if (cnt_is_one) begin
            done_d = 1'b1;
            if (reload_q) begin
              cnt_load     = 1'b1;
              cnt_load_val = period_q;
            end else begin
              cnt_clear = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end

      default: begin
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      period_q <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign tmr.count_o = cnt_count;
  assign tmr.busy_o  = busy_q;
  assign tmr.done_o  = done_q;

endmodule
